// File: rtl/pb_cmd_pkg.sv
// Shared definitions for the push-button command decoder: command codes,
// button bit positions, FSM state encoding and the key priority selector.
package pb_cmd_pkg;

  localparam logic [2:0] CMD_UP    = 3'd0;
  localparam logic [2:0] CMD_DOWN  = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_UNDO  = 3'd4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_UNDO  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Pick one command from a pressed mask: UNDO > UP > DOWN > LEFT > RIGHT.
  // An empty mask returns CMD_UP; callers only use the result when mask != 0.
  function automatic logic [2:0] sel_key(input logic [4:0] mask);
    logic [2:0] code;
    if (mask[BTN_UNDO]) begin
      code = CMD_UNDO;
    end else if (mask[BTN_UP]) begin
      code = CMD_UP;
    end else if (mask[BTN_DOWN]) begin
      code = CMD_DOWN;
    end else if (mask[BTN_LEFT]) begin
      code = CMD_LEFT;
    end else if (mask[BTN_RIGHT]) begin
      code = CMD_RIGHT;
    end else begin
      code = CMD_UP;
    end
    return code;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous first-word-fall-through FIFO. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
// A write while full is accepted only when a read retires an entry on
// the same edge.
module cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk_1ms,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full | do_rd_s);
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer registers; both clear on reset so the FIFO comes up empty.
  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_1ms) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/pb_cmd_decoder.sv
// Push-button to game-command decoder. Turns the debounced active-low
// button vector into one command per press (plus auto-repeat while held
// when PB_CMD_REPEAT_EN is defined) and queues them in a small FWFT FIFO.
// Optional feature macro: PB_CMD_REPEAT_EN.
module pb_cmd_decoder
  import pb_cmd_pkg::*;
#(
  parameter int HOLD_DELAY    = 300,
  parameter int REPEAT_PERIOD = 150,
  parameter int DEPTH         = 4
) (
  input  logic       clk_1ms,
  input  logic       rst_n,
  input  logic [4:0] pb,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd,
  output logic       overflow,
  output logic       held
);

  if ((HOLD_DELAY < 2) || (HOLD_DELAY > 1023) ||
      (REPEAT_PERIOD < 2) || (REPEAT_PERIOD > 1023) ||
      (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_cfg
    $error("pb_cmd_decoder: illegal parameter set");
  end

  logic [4:0] mask_s;
  logic [2:0] sel_s;
  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] cur_key_r;
  logic [2:0] cur_key_nxt_s;
  logic       push_s;
  logic [2:0] push_data_s;
  logic       pop_s;
  logic       overflow_r;
  logic       fifo_empty_s;
  logic       fifo_full_s;
  logic [2:0] fifo_rd_data_s;

  // 5'b00000 is the debouncer's "no key" code, not "all keys pressed".
  assign mask_s = (pb == 5'b00000) ? 5'b00000 : ~pb;
  assign sel_s  = sel_key(mask_s);

`ifdef PB_CMD_REPEAT_EN
  localparam logic [9:0] HOLD_LAST   = 10'(HOLD_DELAY - 1);
  localparam logic [9:0] REPEAT_LAST = 10'(REPEAT_PERIOD - 1);

  logic [9:0] cnt_r;
  logic [9:0] cnt_nxt_s;

  // Next-state, push and hold-counter logic with auto-repeat.
  always_comb begin
    state_nxt_s   = state_r;
    cur_key_nxt_s = cur_key_r;
    push_s        = 1'b0;
    push_data_s   = sel_s;
    cnt_nxt_s     = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = 10'd0;
        if (mask_s != 5'b00000) begin
          push_s        = 1'b1;
          cur_key_nxt_s = sel_s;
          state_nxt_s   = ST_PRESS;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_PRESS, ST_REPEAT: begin
        if (mask_s == 5'b00000) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 10'd0;
        end else if (sel_s != cur_key_r) begin
          push_s        = 1'b1;
          cur_key_nxt_s = sel_s;
          cnt_nxt_s     = 10'd0;
          state_nxt_s   = ST_PRESS;
        end else if ((state_r == ST_PRESS) && (cnt_r == HOLD_LAST)) begin
          push_s      = 1'b1;
          push_data_s = cur_key_r;
          cnt_nxt_s   = 10'd0;
          state_nxt_s = ST_REPEAT;
        end else if ((state_r == ST_REPEAT) && (cnt_r == REPEAT_LAST)) begin
          push_s      = 1'b1;
          push_data_s = cur_key_r;
          cnt_nxt_s   = 10'd0;
        end else begin
          // Saturate rather than wrap.
          cnt_nxt_s = (cnt_r == 10'h3FF) ? cnt_r : (cnt_r + 10'd1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 10'd0;
      end
    endcase
  end

  // Hold counter register.
  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 10'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  // Next-state and push logic: one command per press or key change.
  always_comb begin
    state_nxt_s   = state_r;
    cur_key_nxt_s = cur_key_r;
    push_s        = 1'b0;
    push_data_s   = sel_s;
    case (state_r)
      ST_IDLE: begin
        if (mask_s != 5'b00000) begin
          push_s        = 1'b1;
          cur_key_nxt_s = sel_s;
          state_nxt_s   = ST_PRESS;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (mask_s == 5'b00000) begin
          state_nxt_s = ST_IDLE;
        end else if (sel_s != cur_key_r) begin
          push_s        = 1'b1;
          cur_key_nxt_s = sel_s;
        end else begin
          state_nxt_s = ST_PRESS;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end
`endif

  // FSM state, latched key and overflow pulse registers.
  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cur_key_r  <= CMD_UP;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cur_key_r  <= cur_key_nxt_s;
      overflow_r <= push_s & fifo_full_s & ~pop_s;
    end
  end

  assign pop_s = ~fifo_empty_s & cmd_ready;

  cmd_fifo #(
    .WIDTH (3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_1ms (clk_1ms),
    .rst_n   (rst_n),
    .wr_en   (push_s),
    .wr_data (push_data_s),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_data_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  assign cmd_valid = ~fifo_empty_s;
  assign cmd       = fifo_empty_s ? 3'd0 : fifo_rd_data_s;
  assign overflow  = overflow_r;
  assign held      = (state_r != ST_IDLE);

endmodule
